spi_fsm: RTL and testbench

Transaction controller for the SPI memory. Sits downstream of the input conditioners, beside the shift register: it counts conditioned SCLK rising-edge pulses during a chip-select-low window and sequences the address latch, data-memory write, shift-register parallel load and MISO buffer enable. The shift register's parallel output bit 0 supplies the read/write flag.

---
 rtl/spi_fsm.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_fsm.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_fsm.sv
// -----------------------------------------------------------------------------
// spi_fsm -- transaction controller for the SPI memory.
//
// Counts conditioned SCLK rising-edge pulses while chip select is low and
// sequences the address latch, data-memory write, shift-register parallel
// load and MISO buffer enable. All control outputs are Moore outputs held in
// registers, so each one is high exactly while the FSM sits in its state and
// all of them clear asynchronously with reset_n.
//
// Optional feature macro: SPI_FSM_BURST_EN
//   defined   : after a completed byte with CS still low, go through INC
//               (pulses addrInc) and continue with the next byte.
//   undefined : INC is unreachable, addrInc is tied 0, completion -> DONE.
//
// Ports
//   clk            in   system clock, all state changes on the rising edge
//   reset_n        in   asynchronous active-low reset
//   csConditioned  in   conditioned chip select (1 = idle, 0 = selected)
//   sclkPosEdge    in   one-clk pulse per SCLK rising edge
//   rwBit          in   shift register parallelDataOut[0] (1 = read)
//   addrWE         out  address latch write enable
//   dmWE           out  data memory write enable
//   srWE           out  shift register parallel load
//   misoBufe       out  MISO tristate buffer enable
//   addrInc        out  address latch increment (burst only)
//   state          out  current state encoding, for debug
// -----------------------------------------------------------------------------
module spi_fsm #(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       csConditioned,
  input  logic       sclkPosEdge,
  input  logic       rwBit,
  output logic       addrWE,
  output logic       dmWE,
  output logic       srWE,
  output logic       misoBufe,
  output logic       addrInc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_GET_ADDR    = 4'd1,
    ST_GOT_ADDR    = 4'd2,
    ST_READ_LOAD   = 4'd3,
    ST_READ_SEND   = 4'd4,
    ST_WRITE_GET   = 4'd5,
    ST_WRITE_STORE = 4'd6,
    ST_DONE        = 4'd7,
    ST_INC         = 4'd8
  } state_t;

  // Counter value at which the closing pulse of each phase is seen: the
  // address phase takes ADDR_BITS+1 pulses (address plus R/W flag).
  localparam logic [3:0] LP_ADDR_LAST = 4'(ADDR_BITS);
  localparam logic [3:0] LP_DATA_LAST = 4'(DATA_BITS - 1);

  // Destination after a completed byte. Any path reaching this decision has
  // already passed the CS-high abort check, so CS is known to be low here.
`ifdef SPI_FSM_BURST_EN
  localparam state_t LP_BYTE_END = ST_INC;
`else
  localparam state_t LP_BYTE_END = ST_DONE;
`endif

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_cnt_en;
  logic       r_addr_we;
  logic       r_dm_we;
  logic       r_sr_we;
  logic       r_miso_bufe;

`ifdef SPI_FSM_BURST_EN
  logic       r_addr_inc;
  logic       r_rw_latch;
`endif

  // Next-state decode; CS high outranks every other event outside IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_en    = 1'b0;
    if ((r_state != ST_IDLE) && csConditioned) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!csConditioned) begin
            w_state_nxt = ST_GET_ADDR;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_GET_ADDR: begin
          w_cnt_en = sclkPosEdge;
          if (sclkPosEdge && (r_cnt == LP_ADDR_LAST)) begin
            w_state_nxt = ST_GOT_ADDR;
          end else begin
            w_state_nxt = ST_GET_ADDR;
          end
        end
        ST_GOT_ADDR: begin
          // The shift register moved on the closing address edge, so its
          // bit 0 now holds the R/W flag.
          if (rwBit) begin
            w_state_nxt = ST_READ_LOAD;
          end else begin
            w_state_nxt = ST_WRITE_GET;
          end
        end
        ST_READ_LOAD: begin
          w_state_nxt = ST_READ_SEND;
        end
        ST_READ_SEND: begin
          w_cnt_en = sclkPosEdge;
          if (sclkPosEdge && (r_cnt == LP_DATA_LAST)) begin
            w_state_nxt = LP_BYTE_END;
          end else begin
            w_state_nxt = ST_READ_SEND;
          end
        end
        ST_WRITE_GET: begin
          w_cnt_en = sclkPosEdge;
          if (sclkPosEdge && (r_cnt == LP_DATA_LAST)) begin
            w_state_nxt = ST_WRITE_STORE;
          end else begin
            w_state_nxt = ST_WRITE_GET;
          end
        end
        ST_WRITE_STORE: begin
          w_state_nxt = LP_BYTE_END;
        end
        ST_DONE: begin
          // SCLK pulses are ignored; only CS high (handled above) leaves DONE.
          w_state_nxt = ST_DONE;
        end
        ST_INC: begin
`ifdef SPI_FSM_BURST_EN
          if (r_rw_latch) begin
            w_state_nxt = ST_READ_LOAD;
          end else begin
            w_state_nxt = ST_WRITE_GET;
          end
`else
          w_state_nxt = ST_IDLE;
`endif
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Edge counter: cleared on every state entry, counts only when enabled.
  always_comb begin
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = 4'd0;
    end else if (w_cnt_en) begin
      w_cnt_nxt = r_cnt + 4'd1;
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Moore outputs registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr_we   <= 1'b0;
      r_dm_we     <= 1'b0;
      r_sr_we     <= 1'b0;
      r_miso_bufe <= 1'b0;
    end else begin
      r_addr_we   <= (w_state_nxt == ST_GOT_ADDR);
      r_dm_we     <= (w_state_nxt == ST_WRITE_STORE);
      r_sr_we     <= (w_state_nxt == ST_READ_LOAD);
      r_miso_bufe <= (w_state_nxt == ST_READ_SEND);
    end
  end

`ifdef SPI_FSM_BURST_EN
  // Burst support: addrInc output and the R/W flag captured in GOT_ADDR,
  // since the shift register no longer holds it once data bytes flow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr_inc <= 1'b0;
      r_rw_latch <= 1'b0;
    end else begin
      r_addr_inc <= (w_state_nxt == ST_INC);
      if (r_state == ST_GOT_ADDR) begin
        r_rw_latch <= rwBit;
      end else begin
        r_rw_latch <= r_rw_latch;
      end
    end
  end

  assign addrInc = r_addr_inc;
`else
  assign addrInc = 1'b0;
`endif

  assign addrWE   = r_addr_we;
  assign dmWE     = r_dm_we;
  assign srWE     = r_sr_we;
  assign misoBufe = r_miso_bufe;
  assign state    = r_state;

endmodule

// File: tb/tb_spi_fsm.sv
// -----------------------------------------------------------------------------
// tb_spi_fsm -- scoreboard bench for spi_fsm.
//
// The stimulus tasks drive SPI transactions (address, R/W flag, data bytes,
// aborts, resets) cycle by cycle and, from the transaction script alone, push
// the state the controller must show in each cycle where something is visible
// (a state change, a high output, or an explicit probe). A separate monitor
// on the falling clock edge pops one entry per visible cycle and compares
// cycle number, state and all five control outputs.
// Follows SPI_FSM_BURST_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_spi_fsm;

`ifdef SPI_FSM_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_GET   = 4'd1;
  localparam logic [3:0] S_GOT   = 4'd2;
  localparam logic [3:0] S_RLOAD = 4'd3;
  localparam logic [3:0] S_RSEND = 4'd4;
  localparam logic [3:0] S_WGET  = 4'd5;
  localparam logic [3:0] S_WST   = 4'd6;
  localparam logic [3:0] S_DONE  = 4'd7;
  localparam logic [3:0] S_INC   = 4'd8;

  typedef struct {
    int         cyc;
    logic [3:0] st;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs = 1'b1;
  logic       sclk = 1'b0;
  logic       rwb = 1'b0;
  logic       addr_we;
  logic       dm_we;
  logic       sr_we;
  logic       miso_be;
  logic       addr_inc;
  logic [3:0] st;

  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  exp_t       exp_q[$];
  bit         probe_at[int];
  logic [3:0] last_exp = 4'd0;
  logic [3:0] mon_prev = 4'd0;
  bit         end_chk = 1'b0;
  int         gap_lo = 1;
  int         gap_hi = 4;
  int         abort_kind = 0;   // 0 none, 1 CS high after pulse, 2 CS high with pulse, 3 reset after pulse
  int         abort_n = 0;

  spi_fsm dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .csConditioned (cs),
    .sclkPosEdge   (sclk),
    .rwBit         (rwb),
    .addrWE        (addr_we),
    .dmWE          (dm_we),
    .srWE          (sr_we),
    .misoBufe      (miso_be),
    .addrInc       (addr_inc),
    .state         (st)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output pattern each state must show: {addrInc, dmWE, misoBufe, srWE, addrWE}.
  function automatic logic [4:0] outs_of(input logic [3:0] s);
    case (s)
      S_GOT:   return 5'b00001;
      S_RLOAD: return 5'b00010;
      S_RSEND: return 5'b00100;
      S_WST:   return 5'b01000;
      S_INC:   return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic push(input int c, input logic [3:0] s, input bit force_chk);
    exp_t r;
    if (force_chk || (s != last_exp) || (outs_of(s) != 5'd0)) begin
      r.cyc = c;
      r.st  = s;
      exp_q.push_back(r);
      if (force_chk) probe_at[c] = 1'b1;
    end
    last_exp = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle; s is the state required in the coming cycle.
  task automatic step(input logic [3:0] s);
    push(cyc + 1, s, 1'b0);
    tick();
  endtask

  // Idle gap in state busy, then one SCLK pulse after which nxt is required.
  task automatic send_pulse(input int n, input logic [3:0] busy, input logic [3:0] nxt, output bit ab);
    int g;
    ab = 1'b0;
    g = $urandom_range(gap_hi, gap_lo);
    repeat (g) step(busy);
    if ((abort_kind == 2) && (abort_n == n)) begin
      cs = 1'b1; sclk = 1'b1; step(S_IDLE); sclk = 1'b0;
      ab = 1'b1;
    end else begin
      sclk = 1'b1; step(nxt); sclk = 1'b0;
      if ((abort_kind == 1) && (abort_n == n)) begin
        step(nxt);
        cs = 1'b1; step(S_IDLE);
        ab = 1'b1;
      end else if ((abort_kind == 3) && (abort_n == n)) begin
        // Reset lands inside the current cycle: the entry already queued for
        // it is replaced by IDLE with all outputs low.
        void'(exp_q.pop_back());
        push(cyc, S_IDLE, 1'b1);
        reset_n = 1'b0; cs = 1'b1;
        step(S_IDLE); step(S_IDLE);
        reset_n = 1'b1;
        push(cyc + 1, S_IDLE, 1'b1);
        tick();
        ab = 1'b1;
      end
    end
  endtask

  // One chip-select window: 8 address pulses, then nbytes data bytes.
  task automatic xfer(input bit rw, input int nbytes);
    bit ab;
    int n;
    logic [3:0] busy;
    n = 0;
    rwb = ~rw; cs = 1'b0; step(S_GET);
    for (int a = 1; a <= 8; a++) begin
      n++;
      send_pulse(n, S_GET, (a == 8) ? S_GOT : S_GET, ab);
      if (ab) return;
    end
    rwb = rw; step(rw ? S_RLOAD : S_WGET);
    rwb = 1'($urandom_range(1, 0));
    for (int b = 0; b < nbytes; b++) begin
      if ((b > 0) && !BURST) begin
        for (int d = 1; d <= 8; d++) begin
          n++;
          send_pulse(n, S_DONE, S_DONE, ab);
          if (ab) return;
        end
      end else begin
        if (rw) step(S_RSEND);
        busy = rw ? S_RSEND : S_WGET;
        for (int d = 1; d <= 8; d++) begin
          n++;
          if (d < 8) send_pulse(n, busy, busy, ab);
          else if (!rw) send_pulse(n, busy, S_WST, ab);
          else if (!BURST) send_pulse(n, busy, S_DONE, ab);
          else if (b < nbytes - 1) send_pulse(n, busy, S_INC, ab);
          else begin
            // Closing a read burst: CS rises with the final pulse and wins.
            repeat ($urandom_range(gap_hi, gap_lo)) step(busy);
            cs = 1'b1; sclk = 1'b1; step(S_IDLE); sclk = 1'b0;
            return;
          end
          if (ab) return;
        end
        if (!rw) begin
          if (!BURST) step(S_DONE);
          else if (b < nbytes - 1) step(S_INC);
          else begin
            cs = 1'b1; step(S_IDLE);
            return;
          end
        end
        if (BURST && (b < nbytes - 1)) step(rw ? S_RLOAD : S_WGET);
      end
    end
    // Stray pulse in DONE must be ignored.
    repeat (2) step(S_DONE);
    sclk = 1'b1; step(S_DONE); sclk = 1'b0;
    step(S_DONE);
  endtask

  task automatic finish_xfer();
    cs = 1'b1; sclk = 1'b0;
    step(S_IDLE); step(S_IDLE);
    abort_kind = 0;
  endtask

  // Scoreboard monitor: one comparison per visible cycle.
  always @(negedge clk) begin : monitor
    exp_t       rec;
    logic [4:0] got;
    got = {addr_inc, dm_we, miso_be, sr_we, addr_we};
    if (end_chk) begin
      vectors <= vectors + 1;
      if (exp_q.size() != 0) begin
        miscompares <= miscompares + 1;
        $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
      end
    end else if ((st != mon_prev) || (got != 5'd0) || probe_at.exists(cyc)) begin
      vectors <= vectors + 1;
      if (exp_q.size() == 0) begin
        miscompares <= miscompares + 1;
        $display("FAIL unexpected cyc %0d: got state %0d outs %b, required no activity", cyc, st, got);
      end else begin
        rec = exp_q.pop_front();
        if ((rec.cyc != cyc) || (rec.st != st) || (outs_of(rec.st) != got)) begin
          miscompares <= miscompares + 1;
          $display("FAIL event cyc %0d: got state %0d outs %b, required cyc %0d state %0d outs %b",
                   cyc, st, got, rec.cyc, rec.st, outs_of(rec.st));
        end
      end
    end
    mon_prev <= st;
  end

  initial begin
    bit rw;
    int nb;
    int sel;
    int r;
    // Reset state: IDLE, all outputs low while reset_n is held low.
    push(1, S_IDLE, 1'b1);
    push(2, S_IDLE, 1'b1);
    tick(); tick();
    reset_n = 1'b1;
    step(S_IDLE); step(S_IDLE);

    // Directed cases with a fixed 4-clk pulse period.
    gap_lo = 3; gap_hi = 3;
    xfer(1'b0, 1); finish_xfer();                                  // write
    xfer(1'b1, 1); finish_xfer();                                  // read
    abort_kind = 1; abort_n = 13; xfer(1'b0, 1); finish_xfer();    // abort after 5th data pulse
    abort_kind = 2; abort_n = 8;  xfer(1'b0, 1); finish_xfer();    // CS high with 8th address pulse
    abort_kind = 2; abort_n = 16; xfer(1'b0, 1); finish_xfer();    // CS high with 8th write-data pulse
    abort_kind = 3; abort_n = 12; xfer(1'b1, 1); finish_xfer();    // reset during READ_SEND
    xfer(1'b1, 3); finish_xfer();                                  // read + 16 further pulses
    xfer(1'b0, 2); finish_xfer();                                  // write + 8 further pulses

    // Randomized transactions, gaps of 2..5 clk between pulses.
    gap_lo = 1; gap_hi = 4;
    for (int t = 0; t < 40; t++) begin
      rw  = 1'($urandom_range(1, 0));
      nb  = $urandom_range(3, 1);
      sel = $urandom_range(9, 0);
      if ((sel == 6) || (sel == 7)) begin
        r = $urandom_range(14, 1);
        abort_kind = 1; abort_n = (r <= 7) ? r : r + 1;
      end else if (sel == 8) begin
        abort_kind = 2; abort_n = $urandom_range(16, 1);
      end else if ((sel == 9) && rw) begin
        abort_kind = 3; abort_n = $urandom_range(15, 9);
      end else begin
        abort_kind = 0;
      end
      xfer(rw, nb);
      finish_xfer();
      repeat ($urandom_range(3, 0)) step(S_IDLE);
    end

    repeat (4) step(S_IDLE);
    end_chk = 1'b1; tick();
    end_chk = 1'b0; tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
